// File: rtl/ahb_mem_slave_pkg.sv
// Shared AHB encodings, FSM state enum and byte-lane helper for the AHB memory slave.
// Defining AHB_MEM_SLAVE_WAIT_STATE_EN adds the WAIT state to the FSM enum.
package AhbGlobalPackage;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
        , ST_WAIT = 3'd1
`endif
    } state_e;

    // Little-endian lane selection; illegal sizes select no lanes.
    function automatic logic [3:0] byteEnable(input logic [2:0] size, input logic [1:0] addrLo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addrLo;
            HSIZE_HALF: return addrLo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_slave_array.sv
// Word-organised storage for the AHB memory slave: byte-lane write enables,
// combinational read port. Contents are deliberately not reset.
module ahb_mem_slave_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with pipelined address/data phases, two-cycle ERROR response
// and write-to-read forwarding. AHB_MEM_SLAVE_WAIT_STATE_EN enables WAIT_STATES wait cycles.
module ahb_mem_slave
    import AhbGlobalPackage::*;
#(
    parameter int ADDR_WIDTH  = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = AHB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hselx,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [1:0]            hresp
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_e                state_q;
    logic                  hreadyout_q;
    logic [1:0]            hresp_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] hrdata_d;
    logic [IDX_W+1:0]      addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  err_q;
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
    logic [3:0]            cnt_q;
`endif

    logic                  accept;
    logic                  errNow;
    logic [3:0]            wrBe;
    logic [IDX_W-1:0]      rdIdx;
    logic [31:0]           memRdata;
    logic                  unused_sideband;

    assign accept = hselx && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    assign errNow = (hsize > HSIZE_WORD)
                 || ((hsize == HSIZE_HALF) && haddr[0])
                 || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                 || (64'(haddr) >= 64'(MEM_DEPTH) * 64'd4);

    assign wrBe = (state_q == ST_DATA && write_q && !err_q) ? byteEnable(size_q, addr_q[1:0]) : 4'b0000;

    // A read leaving WAIT uses the registered address; zero-wait reads use the live one.
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
    assign rdIdx = (state_q == ST_WAIT) ? addr_q[IDX_W+1:2] : haddr[IDX_W+1:2];
    assign unused_sideband = ^{hburst, hprot, hmastlock};
`else
    assign rdIdx = haddr[IDX_W+1:2];
    assign unused_sideband = ^{hburst, hprot, hmastlock, 4'(WAIT_STATES)};
`endif

    ahb_mem_slave_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (hclk),
        .we_i    (wrBe),
        .waddr_i (addr_q[IDX_W+1:2]),
        .wdata_i (hwdata),
        .raddr_i (rdIdx),
        .rdata_o (memRdata)
    );

    // Merge lanes being written this very edge so a pipelined read sees them.
    always_comb begin
        hrdata_d = memRdata;
        if (addr_q[IDX_W+1:2] == rdIdx) begin
            for (int b = 0; b < 4; b++) begin
                if (wrBe[b]) begin
                    hrdata_d[8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'b000;
            err_q       <= 1'b0;
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
            cnt_q       <= 4'd0;
`endif
        end else begin
            case (state_q)
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= ST_DATA;
                        hreadyout_q <= 1'b1;
                        cnt_q       <= 4'd0;
                        if (!write_q) begin
                            hrdata_q <= hrdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
`endif
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= haddr[IDX_W+1:0];
                        write_q <= hwrite;
                        size_q  <= hsize;
                        err_q   <= errNow;
                        if (errNow) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
                            if (WAIT_STATES > 0) begin
                                state_q     <= ST_WAIT;
                                cnt_q       <= 4'(WAIT_STATES);
                                hreadyout_q <= 1'b0;
                                hresp_q     <= HRESP_OKAY;
                            end else begin
`endif
                                state_q     <= ST_DATA;
                                hreadyout_q <= 1'b1;
                                hresp_q     <= HRESP_OKAY;
                                if (!hwrite) begin
                                    hrdata_q <= hrdata_d;
                                end
`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
                            end
`endif
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed self-checking bench for ahb_mem_slave in a single-slave system (hready = hreadyout).
// Expected wait count follows AHB_MEM_SLAVE_WAIT_STATE_EN: 2 when defined, 0 otherwise.
module tb_ahb_mem_slave;

`ifdef AHB_MEM_SLAVE_WAIT_STATE_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        hclk;
    logic        hresetn;
    logic        hselx;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    int total;
    int bad;

    ahb_mem_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (1024),
        .WAIT_STATES (2)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hselx     (hselx),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    assign hready = hreadyout;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Single transfer: address phase, then data phase until hreadyout rises (bounded).
    task automatic doTransfer(input logic [31:0] addr, input logic write, input logic [2:0] size,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output int lows, output logic [1:0] respLow, output logic [1:0] respEnd);
        bit done;
        @(negedge hclk);
        hselx  = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = write;
        hsize  = size;
        @(negedge hclk);
        hselx   = 1'b0;
        htrans  = 2'b00;
        hwdata  = wdata;
        lows    = 0;
        respLow = 2'b00;
        done    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (hreadyout === 1'b1) begin
                done = 1'b1;
                break;
            end
            lows++;
            respLow = respLow | hresp;
            @(negedge hclk);
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL transfer_timeout addr=%h got_hreadyout=%b want=1", addr, hreadyout);
        end
        respEnd = hresp;
        rdata   = hrdata;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        total++;
        if (hreadyout !== 1'b1) begin bad++; $display("[TB] FAIL reset_hreadyout got=%b want=1", hreadyout); end
        total++;
        if (hresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_hresp got=%b want=00", hresp); end
        total++;
        if (hrdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_hrdata got=%h want=00000000", hrdata); end
        hresetn = 1'b1;
    endtask

    task automatic test_write_wait();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        doTransfer(32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd, lows, rl, re);
        total++;
        if (lows != EXP_WAIT) begin bad++; $display("[TB] FAIL write_wait_cycles got=%0d want=%0d", lows, EXP_WAIT); end
        total++;
        if (rl !== 2'b00) begin bad++; $display("[TB] FAIL write_wait_resp got=%b want=00", rl); end
        total++;
        if (re !== 2'b00) begin bad++; $display("[TB] FAIL write_end_resp got=%b want=00", re); end
        doTransfer(32'h10, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (lows != EXP_WAIT) begin bad++; $display("[TB] FAIL read_latency got=%0d want=%0d", lows, EXP_WAIT); end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL read_0x10 got=%h want=DEADBEEF", rd); end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h10; hsize = 3'b010;
        @(negedge hclk);
        hwdata = 32'hFFFFFFFF; htrans = 2'b01;
        total++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00) begin bad++; $display("[TB] FAIL idle_okay got=%b/%b want=1/00", hreadyout, hresp); end
        @(negedge hclk);
        hselx = 1'b0; htrans = 2'b10;
        total++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00) begin bad++; $display("[TB] FAIL busy_okay got=%b/%b want=1/00", hreadyout, hresp); end
        @(negedge hclk);
        htrans = 2'b00;
        total++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00) begin bad++; $display("[TB] FAIL unselected_okay got=%b/%b want=1/00", hreadyout, hresp); end
        doTransfer(32'h10, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL idle_no_write got=%h want=DEADBEEF", rd); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        doTransfer(32'h13, 1'b1, 3'b000, 32'hAA000000, rd, lows, rl, re);
        doTransfer(32'h10, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hAAADBEEF) begin bad++; $display("[TB] FAIL byte_write got=%h want=AAADBEEF", rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        doTransfer(32'h11, 1'b1, 3'b001, 32'h55555555, rd, lows, rl, re);
        total++;
        if (lows != 1) begin bad++; $display("[TB] FAIL err1_cycles got=%0d want=1", lows); end
        total++;
        if (rl !== 2'b01) begin bad++; $display("[TB] FAIL err1_resp got=%b want=01", rl); end
        total++;
        if (re !== 2'b01) begin bad++; $display("[TB] FAIL err2_resp got=%b want=01", re); end
        doTransfer(32'h10, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hAAADBEEF) begin bad++; $display("[TB] FAIL err_mem_untouched got=%h want=AAADBEEF", rd); end
        doTransfer(32'h40, 1'b1, 3'b011, 32'h0, rd, lows, rl, re);
        total++;
        if (re !== 2'b01 || lows != 1) begin bad++; $display("[TB] FAIL err_bad_size got=%b/%0d want=01/1", re, lows); end
        doTransfer(32'h1000, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (re !== 2'b01 || lows != 1) begin bad++; $display("[TB] FAIL err_out_of_range got=%b/%0d want=01/1", re, lows); end
        doTransfer(32'h12, 1'b1, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (re !== 2'b01 || lows != 1) begin bad++; $display("[TB] FAIL err_word_misaligned got=%b/%0d want=01/1", re, lows); end
    endtask

    task automatic test_half_and_top();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        doTransfer(32'h12, 1'b1, 3'b001, 32'hBBBB0000, rd, lows, rl, re);
        total++;
        if (re !== 2'b00) begin bad++; $display("[TB] FAIL half_resp got=%b want=00", re); end
        doTransfer(32'h10, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hBBBBBEEF) begin bad++; $display("[TB] FAIL half_write got=%h want=BBBBBEEF", rd); end
        doTransfer(32'hFFC, 1'b1, 3'b010, 32'h55AA33CC, rd, lows, rl, re);
        doTransfer(32'hFFC, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'h55AA33CC || re !== 2'b00) begin bad++; $display("[TB] FAIL top_word got=%h/%b want=55AA33CC/00", rd, re); end
    endtask

    task automatic test_back_to_back();
        int wLows;
        int rLows;
        bit done;
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'b010;
        @(negedge hclk);
        hwdata = 32'h12345678;
        haddr  = 32'h20; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
        wLows = 0;
        done  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (hreadyout === 1'b1) begin done = 1'b1; break; end
            wLows++;
            @(negedge hclk);
        end
        total++;
        if (!done || wLows != EXP_WAIT) begin bad++; $display("[TB] FAIL b2b_write_wait got=%0d want=%0d", wLows, EXP_WAIT); end
        @(negedge hclk);
        hselx = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        rLows = 0;
        done  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (hreadyout === 1'b1) begin done = 1'b1; break; end
            rLows++;
            @(negedge hclk);
        end
        total++;
        if (!done || rLows != EXP_WAIT) begin bad++; $display("[TB] FAIL b2b_no_gap got=%0d want=%0d", rLows, EXP_WAIT); end
        total++;
        if (hrdata !== 32'h12345678 || hresp !== 2'b00) begin bad++; $display("[TB] FAIL b2b_read got=%h/%b want=12345678/00", hrdata, hresp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lows;
        logic [1:0] rl, re;
        doTransfer(32'h30, 1'b1, 3'b010, 32'hCAFEF00D, rd, lows, rl, re);
        doTransfer(32'h30, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL pre_reset_read got=%h want=CAFEF00D", rd); end
        @(negedge hclk);
        hselx = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'b010;
        @(negedge hclk);
        hselx = 1'b0; htrans = 2'b00; hwdata = 32'h0BADBEEF;
        hresetn = 1'b0;
        #2;
        total++;
        if (hreadyout !== 1'b1 || hresp !== 2'b00 || hrdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset_outputs got=%b/%b/%h want=1/00/00000000", hreadyout, hresp, hrdata);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        doTransfer(32'h30, 1'b0, 3'b010, 32'h0, rd, lows, rl, re);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL aborted_write got=%h want=CAFEF00D", rd); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        hresetn   = 1'b0;
        hselx     = 1'b0;
        haddr     = 32'h0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        hsize     = 3'b000;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        hmastlock = 1'b0;
        hwdata    = 32'h0;
        test_reset();
        test_write_wait();
        test_idle_busy();
        test_byte_write();
        test_error();
        test_half_and_top();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
